bht_controller: RTL and testbench

//  Controls the 2-bit saturating-counter branch history table (BHT) array in the fetch stage.

---
 rtl/bht_controller.sv | 147 ++++++++++++++
 tb/tb_bht_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bht_controller.sv
// bht_controller: controller for the 2-bit saturating-counter branch history
// table in the fetch stage.
//  - After reset, sweeps every table entry to INIT_VALUE (INIT state).
//  - In RUN, serves zero-latency taken/not-taken predictions from read port 1.
//  - Applies resolved-branch updates as a one-stage read-modify-write
//    (accept -> U1: read port 2, saturate, write back).
//  - Owns the global history register that is hashed into the table index.
// Ports:
//  clk, reset_n                  clock, synchronous active-low reset
//  lookup_pc                     fetch PC (bit 0 ignored)
//  predict_taken/predict_valid   prediction to fetch
//  pred_index                    hashed lookup index, carried down the pipe
//  upd_valid/upd_ready           resolved-branch update handshake
//  upd_index/upd_taken           update target and actual outcome
//  arr_read1_index/arr_data1_out array lookup port
//  arr_read2_index/arr_data2_out array update-read port
//  arr_write/arr_write_index/arr_datain  array write port
module bht_controller #(
  parameter int INDEX_BITS = 5,
  parameter int CTR_WIDTH  = 2,
  parameter int HIST_BITS  = 3,
  parameter int INIT_VALUE = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           lookup_pc,
  output logic                  predict_taken,
  output logic                  predict_valid,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  output logic [INDEX_BITS-1:0] arr_read1_index,
  input  logic [CTR_WIDTH-1:0]  arr_data1_out,
  output logic [INDEX_BITS-1:0] arr_read2_index,
  input  logic [CTR_WIDTH-1:0]  arr_data2_out,
  output logic                  arr_write,
  output logic [INDEX_BITS-1:0] arr_write_index,
  output logic [CTR_WIDTH-1:0]  arr_datain
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
  localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0]  INIT_CTR = CTR_WIDTH'(INIT_VALUE);

  state_t                state, state_nxt;
  logic [INDEX_BITS-1:0] init_ctr;
  logic [HIST_BITS-1:0]  ghr;
  logic [HIST_BITS:0]    ghr_sh;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic                  u1_valid;
  logic [INDEX_BITS-1:0] u1_index;
  logic                  u1_taken;
  logic [CTR_WIDTH-1:0]  u1_next;
  logic [CTR_WIDTH-1:0]  lk_ctr;
  logic                  bypass;
  logic                  upd_acc;
  logic                  unused_pc_bits;

  // Only PC[INDEX_BITS:1] feeds the hash.
  assign unused_pc_bits = ^{lookup_pc[15:INDEX_BITS+1], lookup_pc[0]};

  // GHR zero-extended into the low bits of the index.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_BITS-1:0] = ghr;
  end

  assign pred_index      = lookup_pc[INDEX_BITS:1] ^ ghr_ext;
  assign arr_read1_index = pred_index;
  assign arr_read2_index = u1_index;

  // Shifted history; dropping the top bit keeps this legal for HIST_BITS=1.
  assign ghr_sh  = {ghr, upd_taken};
  assign upd_acc = upd_valid && upd_ready;

  // Saturating update of the counter read on port 2.
  always_comb begin
    u1_next = arr_data2_out;
    if (u1_taken) begin
      if (arr_data2_out != CTR_MAX) u1_next = arr_data2_out + 1'b1;
    end else begin
      if (arr_data2_out != '0) u1_next = arr_data2_out - 1'b1;
    end
  end

  // The array has not yet committed the U1 write, so forward it.
  assign bypass = u1_valid && (u1_index == pred_index);
  assign lk_ctr = bypass ? u1_next : arr_data1_out;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_INIT;
      init_ctr <= '0;
      ghr      <= '0;
      u1_valid <= 1'b0;
      u1_index <= '0;
      u1_taken <= 1'b0;
    end else begin
      state    <= state_nxt;
      u1_valid <= upd_acc;
      if (state == S_INIT) init_ctr <= init_ctr + 1'b1;
      if (upd_acc) begin
        u1_index <= upd_index;
        u1_taken <= upd_taken;
        ghr      <= ghr_sh[HIST_BITS-1:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    upd_ready     = 1'b0;
    predict_valid = 1'b0;
    case (state)
      S_INIT: if (init_ctr == LAST_IDX) state_nxt = S_RUN;
      S_RUN: begin
        upd_ready     = 1'b1;
        predict_valid = 1'b1;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign predict_taken = predict_valid && lk_ctr[CTR_WIDTH-1];

  // Writes are suppressed while reset is asserted so a pending U1 update
  // (or a half-done sweep) never reaches the array on the reset edge.
  always_comb begin
    arr_write       = 1'b0;
    arr_write_index = u1_index;
    arr_datain      = u1_next;
    if (reset_n) begin
      if (state == S_INIT) begin
        arr_write       = 1'b1;
        arr_write_index = init_ctr;
        arr_datain      = INIT_CTR;
      end else if (u1_valid) begin
        arr_write = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bht_controller.sv
module tb_bht_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [15:0] lookup_pc;
  logic       predict_taken, predict_valid;
  logic [4:0] pred_index;
  logic       upd_valid, upd_ready;
  logic [4:0] upd_index;
  logic       upd_taken;
  logic [4:0] arr_read1_index, arr_read2_index, arr_write_index;
  logic [1:0] arr_data1_out, arr_data2_out, arr_datain;
  logic       arr_write;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed { logic [4:0] idx; logic [1:0] data; } wr_t;
  typedef struct packed { logic [4:0] idx; logic taken; } pr_t;
  wr_t wq[$];
  pr_t pq[$];
  logic lk_chk = 1'b0;

  // Behavioural table: combinational reads, write at the clock edge.
  logic [1:0] mem [32];

  always #5 clk = ~clk;

  bht_controller dut (
    .clk(clk), .reset_n(reset_n), .lookup_pc(lookup_pc),
    .predict_taken(predict_taken), .predict_valid(predict_valid),
    .pred_index(pred_index), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_index(upd_index), .upd_taken(upd_taken),
    .arr_read1_index(arr_read1_index), .arr_data1_out(arr_data1_out),
    .arr_read2_index(arr_read2_index), .arr_data2_out(arr_data2_out),
    .arr_write(arr_write), .arr_write_index(arr_write_index),
    .arr_datain(arr_datain)
  );

  assign arr_data1_out = mem[arr_read1_index];
  assign arr_data2_out = mem[arr_read2_index];
  always @(posedge clk) if (arr_write) mem[arr_write_index] <= arr_datain;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every array write and every flagged lookup is matched
  // against the next expected entry.
  always @(negedge clk) begin
    if (arr_write) begin
      if (wq.size() == 0) check("unexpected_write", 1, 0);
      else begin
        wr_t w;
        w = wq.pop_front();
        check("write_index", int'(arr_write_index), int'(w.idx));
        check("write_data", int'(arr_datain), int'(w.data));
      end
    end
    if (lk_chk) begin
      if (pq.size() == 0) check("unexpected_lookup", 1, 0);
      else begin
        pr_t p;
        p = pq.pop_front();
        check("pred_index", int'(pred_index), int'(p.idx));
        check("predict_taken", int'(predict_taken), int'(p.taken));
        check("predict_valid", int'(predict_valid), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset, expect a full 32-entry sweep then RUN on cycle 33.
  task automatic init_sweep();
    for (int i = 0; i < 32; i++) wq.push_back('{idx: 5'(i), data: 2'b01});
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("init_upd_ready", int'(upd_ready), 0);
      check("init_predict_valid", int'(predict_valid), 0);
      check("init_predict_taken", int'(predict_taken), 0);
      #1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("run_upd_ready", int'(upd_ready), 1);
    check("run_predict_valid", int'(predict_valid), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [15:0] pc, input logic [4:0] idx, input logic tk);
    lookup_pc = pc;
    pq.push_back('{idx: idx, taken: tk});
    lk_chk = 1'b1;
    tick();
    lk_chk = 1'b0;
  endtask

  // Issue one update; exp is the hand-computed counter written in U1.
  task automatic upd(input logic [4:0] idx, input logic tk, input logic [1:0] exp);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_taken = tk;
    wq.push_back('{idx: idx, data: exp});
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 2'b11;
    reset_n = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;

    // 1. reset for 3 cycles, then sweep
    repeat (3) begin
      @(negedge clk);
      check("reset_arr_write", int'(arr_write), 0);
      check("reset_upd_ready", int'(upd_ready), 0);
      tick();
    end
    init_sweep();

    // 2. basic predict and two taken updates
    lookup(16'h0004, 5'd2, 1'b0);
    upd(5'd2, 1'b1, 2'b10);
    upd(5'd2, 1'b1, 2'b11);      // ghr = 011
    tick();
    lookup(16'h0002, 5'd2, 1'b1); // 00001 ^ 011 = 2
    lookup(16'h000A, 5'd6, 1'b0); // 00101 ^ 011 = 6, still 01

    // 3. saturation both ways
    upd(5'd2, 1'b1, 2'b11);
    upd(5'd2, 1'b1, 2'b11);
    upd(5'd2, 1'b1, 2'b11);      // ghr = 111
    upd(5'd2, 1'b0, 2'b10);
    upd(5'd2, 1'b0, 2'b01);
    upd(5'd2, 1'b0, 2'b00);
    upd(5'd2, 1'b0, 2'b00);
    upd(5'd2, 1'b0, 2'b00);      // ghr = 000
    tick();
    lookup(16'h0004, 5'd2, 1'b0);

    // 4. bypass: lookup in the U1 cycle of a taken update to idx 5
    upd(5'd5, 1'b1, 2'b10);      // ghr = 001
    lookup(16'h0008, 5'd5, 1'b1); // 00100 ^ 001 = 5, array still 01
    lookup(16'h0008, 5'd5, 1'b1); // now from the committed array

    // 5. ghr: clear with three not-taken, then T,N,T
    upd(5'd9, 1'b0, 2'b00);
    upd(5'd9, 1'b0, 2'b00);
    upd(5'd9, 1'b0, 2'b00);      // ghr = 000
    upd(5'd12, 1'b1, 2'b10);
    upd(5'd12, 1'b0, 2'b01);
    upd(5'd12, 1'b1, 2'b10);     // ghr = 101
    tick();
    lookup(16'h0000, 5'd5, 1'b1);

    // 6a. reset mid-sweep at init_ctr = 10
    reset_n = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) wq.push_back('{idx: 5'(i), data: 2'b01});
    reset_n = 1'b1;
    repeat (10) tick();
    reset_n = 1'b0;
    @(negedge clk);
    check("midinit_reset_no_write", int'(arr_write), 0);
    tick();
    tick();
    init_sweep();
    lookup(16'h0004, 5'd2, 1'b0);

    // 6b. reset while an update is pending in U1: nothing written
    upd_valid = 1'b1; upd_index = 5'd7; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("pending_upd_dropped", int'(arr_write), 0);
    tick();
    init_sweep();
    lookup(16'h000E, 5'd7, 1'b0); // idx 7 remains 01

    check("write_queue_drained", wq.size(), 0);
    check("pred_queue_drained", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
